// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: adder/subtractor that resolves one GROUP-bit carry-lookahead group per pipeline stage,
// with a valid/ready handshake on both sides and a global stall driven by output backpressure.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int L = WIDTH / GROUP;

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [L-1:0]     v_q, v_d, c_q, c_d;
    logic [WIDTH-1:0] a_q [L];
    logic [WIDTH-1:0] b_q [L];
    logic [WIDTH-1:0] s_q [L];
    logic [WIDTH-1:0] a_d [L];
    logic [WIDTH-1:0] b_d [L];
    logic [WIDTH-1:0] s_d [L];
    logic [GROUP+1:0] r [L];
    logic             ovf_q, zero_q, ovf_d, zero_d;

    // Returns {carry into group MSB, group carry-out, group sum}; every carry is a flat sum of products.
    function automatic logic [GROUP+1:0] cla(input logic [GROUP-1:0] x, input logic [GROUP-1:0] y,
                                             input logic ci);
        logic [GROUP-1:0] p, g;
        logic [GROUP:0]   c;
        logic             t;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            t = ci;
            for (int m = 0; m <= i; m++) t = t & p[m];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) t = t & p[m];
                c[i+1] = c[i+1] | t;
            end
        end
        return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    assign stall     = v_q[L-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v_q[L-1];
    assign sum       = s_q[L-1];
    assign cout      = c_q[L-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign b_eff     = sub ? ~b : b;
    assign c0        = sub | cin;

    // Operands shift down by GROUP each stage so the next group always sits in the low bits.
    always_comb begin
        r[0]   = cla(a[GROUP-1:0], b_eff[GROUP-1:0], c0);
        a_d[0] = a >> GROUP;
        b_d[0] = b_eff >> GROUP;
        s_d[0] = WIDTH'(r[0][GROUP-1:0]);
        c_d[0] = r[0][GROUP];
        v_d[0] = in_valid;
        for (int k = 1; k < L; k++) begin
            r[k]   = cla(a_q[k-1][GROUP-1:0], b_q[k-1][GROUP-1:0], c_q[k-1]);
            a_d[k] = a_q[k-1] >> GROUP;
            b_d[k] = b_q[k-1] >> GROUP;
            s_d[k] = s_q[k-1] | (WIDTH'(r[k][GROUP-1:0]) << (k * GROUP));
            c_d[k] = r[k][GROUP];
            v_d[k] = v_q[k-1];
        end
        ovf_d  = r[L-1][GROUP+1] ^ r[L-1][GROUP];
        zero_d = s_d[L-1] == '0;
    end

    // The final stage only loads on a real result, so outputs hold through bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < L; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (!stall) begin
            v_q <= v_d;
            for (int k = 0; k < L; k++) begin
                if (k < L - 1 || v_d[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
            if (v_d[L-1]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: table vectors, latency, backpressure, mid-flight reset and random streaming,
// all checked through an in-order expected-result queue.
module tb_pipelined_cla_adder;
    localparam int W = 16;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout, ovf, zero;
    logic [W-1:0] sum;

    typedef struct packed {logic [W-1:0] sum; logic cout, ovf, zero;} res_t;
    typedef struct packed {logic [W-1:0] a, b; logic cin, sub; res_t want;} vec_t;

    vec_t pend[$];
    res_t exp_q[$];
    int   tests = 0, fails = 0;
    res_t held;
    logic was_stalled = 1'b0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
        .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
        .zero(zero)
    );

    function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s);
        logic [W-1:0] yy;
        logic [W:0]   f;
        yy = s ? ~y : y;
        f  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s | ci};
        model.sum  = f[W-1:0];
        model.cout = f[W];
        model.ovf  = (x[W-1] == yy[W-1]) && (f[W-1] != x[W-1]);
        model.zero = f[W-1:0] == '0;
    endfunction

    function automatic vec_t mk(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s,
                                logic [W-1:0] es, logic co, logic ov, logic z);
        mk.a = x;
        mk.b = y;
        mk.cin = ci;
        mk.sub = s;
        mk.want.sum = es;
        mk.want.cout = co;
        mk.want.ovf = ov;
        mk.want.zero = z;
    endfunction

    function automatic vec_t rnd();
        logic [W-1:0] x, y;
        logic ci, s;
        x = W'($urandom);
        y = W'($urandom);
        ci = 1'($urandom);
        s = 1'($urandom);
        rnd = mk(x, y, ci, s, '0, 1'b0, 1'b0, 1'b0);
        rnd.want = model(x, y, ci, s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // One clock: present the head of pend, evaluate both handshakes before the edge, then advance.
    task automatic tick(input logic ordy);
        res_t e;
        in_valid = pend.size() != 0;
        if (in_valid) begin
            a = pend[0].a;
            b = pend[0].b;
            cin = pend[0].cin;
            sub = pend[0].sub;
        end
        out_ready = ordy;
        @(negedge clk);
        if (was_stalled && out_valid) chk("hold", 32'({sum, cout, ovf, zero}), 32'(held));
        chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        was_stalled = out_valid && !out_ready;
        held = {sum, cout, ovf, zero};
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious: got sum %0h, required no output", sum);
            end else begin
                e = exp_q.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("zero", 32'(zero), 32'(e.zero));
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(pend[0].want);
            void'(pend.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        repeat (budget) if (pend.size() != 0 || exp_q.size() != 0) tick(1'b1);
        tests++;
        if (pend.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending and %0d outstanding, required 0", pend.size(), exp_q.size());
        end
    endtask

    initial begin
        vec_t tbl[10];
        int n;
        tbl[0] = mk(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[2] = mk(16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[3] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        tbl[4] = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        tbl[5] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        tbl[6] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[7] = mk(16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[8] = mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        tbl[9] = mk(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_outputs", 32'({sum, cout, ovf, zero}), 32'd0);
        rst = 1'b0;

        pend.push_back(tbl[0]);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1);
            chk("latency", 32'(out_valid), 32'(i == 4));
        end
        drain(20);

        for (int i = 0; i < 10; i++) pend.push_back(tbl[i]);
        drain(60);

        for (int i = 0; i < 6; i++) pend.push_back(rnd());
        n = 0;
        while (!out_valid && n < 20) begin
            tick(1'b1);
            n++;
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (3) tick(1'b0);
        drain(60);

        for (int i = 0; i < 3; i++) pend.push_back(rnd());
        repeat (4) tick(1'b1);
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_out_valid", 32'(out_valid), 32'd0);
        chk("async_reset_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        was_stalled = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_no_accept", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        pend.push_back(tbl[3]);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1);
            chk("post_reset_latency", 32'(out_valid), 32'(i == 4));
        end
        drain(20);
        repeat (6) tick(1'b1);

        for (int i = 0; i < 2000; i++) begin
            if (pend.size() == 0 && $urandom_range(0, 3) != 0) pend.push_back(rnd());
            tick($urandom_range(0, 3) != 0);
        end
        drain(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; SHALL be a multiple of GROUP, minimum 8.
REQ-002 Parameter GROUP, default 4: bits per carry-lookahead group, range 2..8; pipeline depth L = WIDTH/GROUP.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-high.
REQ-005 Port in_valid  input  1: operand set present.
REQ-006 Port in_ready  output  1: block accepts operands this cycle.
REQ-007 Port a, b  input  WIDTH each: operands.
REQ-008 Port cin  input  1: carry-in, used when sub=0.
REQ-009 Port sub  input  1: 1 = subtract (a - b), 0 = add (a + b + cin).
REQ-010 Port out_valid  output  1: result present.
REQ-011 Port out_ready  input  1: downstream accepts result.
REQ-012 Port sum  output  WIDTH: result bits.
REQ-013 Port cout  output  1: carry out of MSB; in subtract mode 1 = no borrow.
REQ-014 Port ovf  output  1: signed two's-complement overflow.
REQ-015 Port zero  output  1: sum == 0.

Function
REQ-016 Accept occurs on a rising edge with in_valid=1 and in_ready=1; otherwise a, b, cin and sub are ignored.
REQ-017 Effective operand b' = sub ? ~b : b; effective carry-in c0 = sub ? 1 : cin; cin is ignored when sub=1.
REQ-018 Each group computes p = a^b', g = a&b' and lookahead carries within the group; no ripple within a group.
REQ-019 Pipeline has L stages; stage k resolves group k (bits k*GROUP..k*GROUP+GROUP-1) using the registered carry-out of stage k-1 (stage 0 uses c0).
REQ-020 Unresolved upper operand bits travel with the transaction; resolved sum bits are registered and carried forward.
REQ-021 Latency: out_valid rises after the L-th rising edge, counting the accepting edge as the first, with no stall in between.
REQ-022 Throughput: one transaction per cycle when out_ready=1; results leave in acceptance order.
REQ-023 Stall condition: stall = out_valid & ~out_ready; while stall=1, every stage register and its valid bit hold.
REQ-024 in_ready = ~stall (combinational); a bubble in the pipeline does not, by itself, block acceptance.
REQ-025 Output hand-off: a result is consumed on a rising edge with out_valid=1 and out_ready=1; sum, cout, ovf and zero stay stable while out_valid=1 and out_ready=0.
REQ-026 ovf = carry into MSB XOR carry out of MSB, for both modes.
REQ-027 zero is computed from the final registered sum; it is not a separate pipeline stage.
REQ-028 Arithmetic is modulo 2^WIDTH; the carry out of the final stage drives cout.
REQ-029 Accept and consume on the same edge with a full pipeline: the oldest result leaves, all stages advance and the new operand set enters stage 0.
REQ-030 When out_valid=0, sum, cout, ovf and zero are don't-care for checking; the implementation holds their last values.

Reset
REQ-031 rst=1 SHALL asynchronously clear all stage valid bits, out_valid, sum, cout, ovf and zero to 0.
REQ-032 While rst=1, in_ready = 1 and the block accepts nothing.
REQ-033 In-flight transactions at reset assertion are discarded and never appear at the output.
REQ-034 After rst deasserts, the first accepted transaction has the normal latency L.

Verification (WIDTH=16, GROUP=4, L=4)
REQ-035 Add: a=0x0002, b=0x0003, cin=0, sub=0 -> 4 cycles later sum=0x0005, cout=0, ovf=0, zero=0.
REQ-036 Full-width carry chain: a=0x0000, b=0xFFFF, cin=1 -> sum=0x0000, cout=1, ovf=0, zero=1. Also a=0x5555, b=0xAAAA, cin=1 -> sum=0x0000, cout=1.
REQ-037 Overflow and subtract:
- a=0x7FFF + b=0x0001 -> sum=0x8000, ovf=1, cout=0.
- sub: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0.
- sub: a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
REQ-038 Streaming with backpressure: present 6 back-to-back transactions and hold out_ready=0 for 3 cycles once out_valid rises -> in_ready=0 during the stall, no loss or duplication, results in order, outputs stable while stalled.
REQ-039 Reset mid-operation: accept 3 transactions, assert rst asynchronously between edges -> out_valid drops to 0 immediately; after release, none of the 3 results appears and a new transaction returns after 4 cycles.
REQ-040 Random regression: 10k random a, b, cin, sub with random in_valid and out_ready, compared against a reference model for every sum, cout, ovf and zero; repeat with WIDTH=32, GROUP=8 and with WIDTH=8, GROUP=2.
